// File: rtl/hwag_pkg.sv
// Shared constants and types for the angle-generator path: wheel geometry,
// pitch width and the crank generator state encoding.
package hwag_pkg;
  localparam int PERIOD_WIDTH = 24;
  localparam int TEETH        = 60;
  localparam int MISSING      = 2;
  localparam int MIN_PERIOD   = 4;
  localparam int TCNT_WIDTH   = 6;

  // Top-angle reference: TDC is referenced to the first tooth after the gap.
  localparam int TOP_TOOTH     = 0;
  localparam int DEG_PER_TOOTH = 360 / TEETH;
  localparam int TOPS_PER_REV  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;
endpackage

// File: rtl/crank_pitch_timer.sv
// Tooth-pitch timer: latches the clamped pitch and counts cycles within it,
// strobing at the last cycle of each pitch.
module crank_pitch_timer #(
  parameter int PERIOD_WIDTH = hwag_pkg::PERIOD_WIDTH,
  parameter int MIN_PERIOD   = hwag_pkg::MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    active,
  input  logic [PERIOD_WIDTH-1:0] tooth_period,
  output logic [PERIOD_WIDTH-1:0] pcnt,
  output logic [PERIOD_WIDTH-1:0] cur_period,
  output logic                    boundary
);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

  logic [PERIOD_WIDTH-1:0] eff;

  always_comb begin
    eff = tooth_period;
    if (tooth_period < MIN_P) eff = MIN_P;
  end

  assign boundary = active && (pcnt == cur_period - PERIOD_WIDTH'(1));

  // The new pitch is only picked up at a boundary so a pitch in flight is
  // never stretched or cut; clear wins so a stop never reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_period <= '0;
      pcnt       <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (start) begin
      cur_period <= eff;
      pcnt       <= '0;
    end else if (active) begin
      if (boundary) begin
        cur_period <= eff;
        pcnt       <= '0;
      end else begin
        pcnt <= pcnt + PERIOD_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 crank wheel and cam phase generator driven by a programmable tooth
// pitch; feeds the angle generator sensor inputs in self-test builds.
module crank_wheel_gen
  import hwag_pkg::*;
#(
  parameter int PERIOD_WIDTH = hwag_pkg::PERIOD_WIDTH,
  parameter int TEETH        = hwag_pkg::TEETH,
  parameter int MISSING      = hwag_pkg::MISSING,
  parameter int MIN_PERIOD   = hwag_pkg::MIN_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PERIOD_WIDTH-1:0] tooth_period,
  output logic                    cap,
  output logic                    cam,
  output logic [5:0]              tooth_num,
  output logic                    rev_start,
  output logic                    running
);
  localparam logic [5:0] LAST_TOOTH = 6'(TEETH - 1);
  localparam logic [5:0] GAP_START  = 6'(TEETH - MISSING);

  gen_state_t              state, next_state;
  logic                    start, stop, active, boundary;
  logic [PERIOD_WIDTH-1:0] pcnt, cur_period, high;
  logic [5:0]              tcnt;
  logic                    phase;

  assign active = (state == RUN);

  crank_pitch_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (stop),
    .active      (active),
    .tooth_period(tooth_period),
    .pcnt        (pcnt),
    .cur_period  (cur_period),
    .boundary    (boundary)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // ena drops immediately; a zero pitch only stops at the end of a tooth.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: if (ena && tooth_period != '0) begin
        next_state = RUN;
        start      = 1'b1;
      end
      RUN: if (!ena || (boundary && tooth_period == '0)) begin
        next_state = IDLE;
        stop       = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else if (stop || !active) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary) begin
      if (tcnt == LAST_TOOTH) begin
        tcnt  <= '0;
        phase <= ~phase;
      end else begin
        tcnt <= tcnt + 6'd1;
      end
    end
  end

  // Decode from state registers only; odd pitches leave the extra cycle low.
  assign high      = cur_period >> 1;
  assign cap       = active && (tcnt < GAP_START) && (pcnt < high);
  assign rev_start = active && (tcnt == '0) && (pcnt == '0);
  assign cam       = phase;
  assign tooth_num = tcnt;
  assign running   = active;
endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Crankshaft/camshaft signal generator: the transmitter side of the angle-generator input path. It synthesises a 60-2 toothed-wheel crank waveform (`cap`) and a once-per-two-revolutions cam phase signal (`cam`) from a programmable tooth pitch in clock cycles. It drives the angle generator's sensor inputs in self-test and HIL builds, and is muxed ahead of the input filter.

## Interface
Parameters:
- `PERIOD_WIDTH`, 24, width of the tooth-pitch value; matches the capture counter width.
- `TEETH`, 60, tooth positions per revolution, including the missing teeth.
- `MISSING`, 2, missing teeth at the end of each revolution.
- `MIN_PERIOD`, 4, smallest accepted pitch in clocks.

Ports:
- `clk`  in  1  module clock.
- `rst`  in  1  asynchronous active-high reset; one clock domain.
- `ena`  in  1  run request.
- `tooth_period`  in  PERIOD_WIDTH  pitch of one tooth position in `clk` cycles; 0 means stop.
- `cap`  out  1  crank sensor waveform.
- `cam`  out  1  cam phase signal; toggles once per revolution.
- `tooth_num`  out  6  current tooth position, 0..TEETH-1.
- `rev_start`  out  1  one-cycle pulse in the first cycle of tooth 0.
- `running`  out  1  high in RUN.

## Operation
- Two states: IDLE and RUN.
- **Registers:** `cur_period` (latched pitch), `pcnt` (cycle within pitch), `tcnt` (tooth position), `phase`.
- **IDLE:**
  - `pcnt`=0, `tcnt`=0, `phase`=0.
  - All outputs low.
- **IDLE→RUN:** on a clock edge where `ena`=1 and `tooth_period`≠0.
  - Latches `eff = max(tooth_period, MIN_PERIOD)` into `cur_period`.
  - Next cycle: `pcnt`=0, `tcnt`=0, `rev_start`=1, `running`=1.
- **RUN, each cycle:**
  - `pcnt` increments.
  - When `pcnt`=`cur_period`-1, the pitch boundary occurs: `pcnt`→0 and `tcnt` increments.
  - `tcnt`=TEETH-1 wraps to 0; on that wrap `phase` toggles and `rev_start` pulses.
- **Waveform:**
  - `high = cur_period >> 1` (floor).
  - `cap`=1 iff `tcnt` < TEETH-MISSING and `pcnt` < `high`.
  - Missing positions (58, 59) are low for the whole pitch, so the gap between falling edges is 3 pitches.
  - Odd pitch puts the extra cycle in the low part. Example: P=9 gives 4 high, 5 low.
- **Period update:**
  - `tooth_period` is sampled only at a pitch boundary, and takes effect from the next pitch.
  - A mid-pitch change never alters the current pitch.
  - Values 1..MIN_PERIOD-1 are clamped to MIN_PERIOD.
- **Stop conditions:**
  - `tooth_period`=0 sampled at a pitch boundary → IDLE.
  - `ena`=0 sampled on any edge in RUN → IDLE immediately, even mid-tooth.
  - IDLE takes priority over the boundary update.
- **Outputs:** `cam`=`phase`; `tooth_num`=`tcnt`.

## Timing
- Reset value of every output and register is 0; IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.
- The output state in a cycle reflects the current `pcnt`/`tcnt`.
- Start latency: `ena` sampled high at edge N → `cap`=1 in the cycle after edge N.
- Stop latency: `ena` sampled low at edge N → all outputs 0 after edge N.
- Restart needs one IDLE cycle minimum.
- Revolution length = TEETH × pitch; `cam` period = 2 × TEETH × pitch.
- `rev_start` is high exactly one cycle per revolution, coincident with the `cam` toggle. It does not coincide with the toggle on the first start: there `cam` stays 0.
- Async `rst` mid-operation → outputs 0 immediately.
- The first edge after `rst` release may start RUN.

## Structure
- `hwag_pkg` holds:
  - PERIOD_WIDTH, TEETH, MISSING, TCNT_WIDTH=6;
  - the shared top-angle constants (used by the angle generator and bench models);
  - the state enum `gen_state_t` {IDLE, RUN}.
- One sub-module is natural: `crank_pitch_timer`. It holds `cur_period`, `pcnt`, clamp, and boundary strobe generation.
- The top level holds `tcnt`, `phase`, the FSM and waveform decode.
- Target 150–250 lines of RTL total.

## Test plan
- Reset, then `ena`=0 → all outputs 0 for 100 cycles; assert `rst` during RUN → outputs 0 in the same cycle.
- `tooth_period`=8, `ena`=1:
  - `cap` is 4 high / 4 low for teeth 0..57, then low for 16 cycles.
  - `rev_start` pulses every 480 cycles; `cam` toggles every 480 cycles.
- `tooth_period` 8→12 written at `pcnt`=3 of tooth 5 → tooth 5 pitch is 8, tooth 6 pitch is 12 (6 high / 6 low).
- `tooth_period`=1 → pitch is 4 (2 high / 2 low); `tooth_period`=9 → 4 high / 5 low.
- Tooth-period stop and restart:
  - `tooth_period`=0 written mid-tooth 10 → stop at the end of tooth 10, `running`=0.
  - Restore 8 → restart from tooth 0 with `cam`=0.
- `ena` dropped at `pcnt`=2 of tooth 57 → next cycle all outputs 0; reassert → `rev_start`=1, `tooth_num`=0.
- Loopback into the angle generator with pitch 100 → `hwag_start` asserts within two revolutions.
